// File: rtl/mult_hilo_ctrl.sv
// mult_hilo_ctrl: issue/retire control around a fixed-latency shift-add multiplier with HI/LO registers.
// Optional signed MULT support is enabled by defining MULT_SIGNED_EN.
module mult_hilo_ctrl #(
    parameter int WIDTH      = 16,
    parameter int MUL_CYCLES = 32
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               ReqValid,
    output logic               ReqReady,
    input  logic [WIDTH-1:0]   OpA,
    input  logic [WIDTH-1:0]   OpB,
`ifdef MULT_SIGNED_EN
    input  logic               ReqSigned,
`endif
    output logic [WIDTH-1:0]   MulA,
    output logic [WIDTH-1:0]   MulB,
    output logic               MulStart,
    input  logic [2*WIDTH-1:0] MulProd,
    input  logic               WrHi,
    input  logic               WrLo,
    input  logic [WIDTH-1:0]   WrData,
    output logic [WIDTH-1:0]   Hi,
    output logic [WIDTH-1:0]   Lo,
    output logic               Busy,
    output logic               Done
);
    localparam int CW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, RUN, CAPTURE} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      count_q, count_d;
    logic [WIDTH-1:0]   mul_a_q, mul_a_d, mul_b_q, mul_b_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic               done_q, done_d;
    logic               accept;
    logic [WIDTH-1:0]   op_a_in, op_b_in;
    logic [2*WIDTH-1:0] prod_fix;

    assign accept = ReqValid && (state_q == IDLE);

`ifdef MULT_SIGNED_EN
    logic neg_q, neg_d;
    // Magnitudes go to the unsigned multiplier; the sign is reapplied at capture.
    assign op_a_in  = (ReqSigned && OpA[WIDTH-1]) ? -OpA : OpA;
    assign op_b_in  = (ReqSigned && OpB[WIDTH-1]) ? -OpB : OpB;
    assign prod_fix = neg_q ? -MulProd : MulProd;
    always_comb begin
        neg_d = accept ? (ReqSigned && (OpA[WIDTH-1] ^ OpB[WIDTH-1])) : neg_q;
    end
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) neg_q <= 1'b0;
        else        neg_q <= neg_d;
    end
`else
    assign op_a_in  = OpA;
    assign op_b_in  = OpB;
    assign prod_fix = MulProd;
`endif

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        mul_a_d = mul_a_q;
        mul_b_d = mul_b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    mul_a_d = op_a_in;
                    mul_b_d = op_b_in;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                count_d = CW'(MUL_CYCLES - 1);
                state_d = RUN;
            end
            RUN: begin
                if (count_q == '0) state_d = CAPTURE;
                else               count_d = count_q - CW'(1);
            end
            default: begin
                {hi_d, lo_d} = prod_fix;
                done_d       = 1'b1;
                state_d      = IDLE;
            end
        endcase
        // An mthi/mtlo in the capture cycle is younger than the mult, so it wins.
        if (WrHi) hi_d = WrData;
        if (WrLo) lo_d = WrData;
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
            count_q <= '0;
            mul_a_q <= '0;
            mul_b_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            mul_a_q <= mul_a_d;
            mul_b_q <= mul_b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    assign ReqReady = (state_q == IDLE);
    assign Busy     = (state_q != IDLE);
    assign MulStart = (state_q == LOAD);
    assign MulA     = mul_a_q;
    assign MulB     = mul_b_q;
    assign Hi       = hi_q;
    assign Lo       = lo_q;
    assign Done     = done_q;
endmodule

// File: tb/tb_mult_hilo_ctrl.sv
// tb_mult_hilo_ctrl: randomized self-checking bench with a latency-accurate multiplier stand-in.
// Build with MULT_SIGNED_EN defined to exercise signed MULT as well.
module tb_mult_hilo_ctrl;
    localparam int W  = 16;
    localparam int MC = 32;
`ifdef MULT_SIGNED_EN
    localparam bit SGN_EN = 1'b1;
`else
    localparam bit SGN_EN = 1'b0;
`endif

    logic          Clk, Reset, ReqValid, ReqReady, ReqSigned, MulStart;
    logic [W-1:0]  OpA, OpB, MulA, MulB, WrData, Hi, Lo;
    logic          WrHi, WrLo, Busy, Done;
    logic [2*W-1:0] MulProd;
    int            mcnt;
    int            n_chk, n_fail;
    logic [W-1:0]  hi_m, lo_m;

    mult_hilo_ctrl #(.WIDTH(W), .MUL_CYCLES(MC)) dut (
        .Clk(Clk), .Reset(Reset), .ReqValid(ReqValid), .ReqReady(ReqReady),
        .OpA(OpA), .OpB(OpB),
`ifdef MULT_SIGNED_EN
        .ReqSigned(ReqSigned),
`endif
        .MulA(MulA), .MulB(MulB), .MulStart(MulStart), .MulProd(MulProd),
        .WrHi(WrHi), .WrLo(WrLo), .WrData(WrData),
        .Hi(Hi), .Lo(Lo), .Busy(Busy), .Done(Done)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Multiplier stand-in: product is valid only MC cycles after restart release, garbage before.
    initial mcnt = 1000;
    always @(posedge Clk) begin
        if (MulStart)         mcnt <= 0;
        else if (mcnt < 1000) mcnt <= mcnt + 1;
    end
    assign MulProd = (mcnt >= MC) ? {16'b0, MulA} * {16'b0, MulB} : 32'hDEAD_BEEF;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_prod(input logic [W-1:0] a, input logic [W-1:0] b, input bit s);
        longint sa, sb, p;
        sa = s ? longint'($signed(a)) : longint'(a);
        sb = s ? longint'($signed(b)) : longint'(b);
        p  = sa * sb;
        return p[31:0];
    endfunction

    function automatic logic [W-1:0] mag(input logic [W-1:0] a, input bit s);
        int v;
        v = s ? int'($signed(a)) : int'(a);
        if (v < 0) v = -v;
        return v[W-1:0];
    endfunction

    // One full mult; lo_k/hi_k pick the cycle (0 = LOAD, 33 = CAPTURE) for an mtlo/mthi, -1 for none.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit s,
                          input bit hold, input logic [W-1:0] na, input logic [W-1:0] nb, input bit ns,
                          input int lo_k, input int hi_k, input logic [W-1:0] ld, input logic [W-1:0] hd);
        int w;
        bit se;
        logic [31:0] p;
        logic [W-1:0] ea, eb;
        se = s & SGN_EN;
        p  = ref_prod(a, b, se);
        ea = mag(a, se);
        eb = mag(b, se);
        ReqValid = 1'b1; OpA = a; OpB = b; ReqSigned = s;
        w = 0;
        while (!ReqReady && w < 100) begin
            @(negedge Clk);
            w++;
        end
        check("ready_wait", 32'(w < 100), 32'd1);
        @(posedge Clk); #1;
        if (hold) begin
            OpA = na; OpB = nb; ReqSigned = ns;
        end else begin
            ReqValid = 1'b0; OpA = W'($urandom); OpB = W'($urandom);
        end
        for (int k = 0; k < MC + 2; k++) begin
            WrLo = (k == lo_k);
            WrHi = (k == hi_k);
            WrData = (k == hi_k) ? hd : ld;
            @(negedge Clk);
            check("mul_start", 32'(MulStart), 32'(k == 0));
            check("busy", 32'(Busy), 32'd1);
            check("ready_busy", 32'(ReqReady), 32'd0);
            check("done_early", 32'(Done), 32'd0);
            check("mul_a", 32'(MulA), 32'(ea));
            check("mul_b", 32'(MulB), 32'(eb));
            check("hi_hold", 32'(Hi), 32'(hi_m));
            check("lo_hold", 32'(Lo), 32'(lo_m));
            @(posedge Clk);
            if (k < MC + 1) begin
                if (WrHi) hi_m = WrData;
                if (WrLo) lo_m = WrData;
            end else begin
                hi_m = WrHi ? WrData : p[31:16];
                lo_m = WrLo ? WrData : p[15:0];
            end
            #1;
        end
        WrLo = 1'b0; WrHi = 1'b0;
        @(negedge Clk);
        check("done", 32'(Done), 32'd1);
        check("busy_done", 32'(Busy), 32'd0);
        check("ready_done", 32'(ReqReady), 32'd1);
        check("hi", 32'(Hi), 32'(hi_m));
        check("lo", 32'(Lo), 32'(lo_m));
    endtask

    initial begin
        logic [W-1:0] ca, cb, xa, xb, ld, hd;
        bit cs, xs, hold;
        int lk, hk, bad;
        n_chk = 0; n_fail = 0;
        Reset = 1'b0; ReqValid = 1'b0; OpA = '0; OpB = '0; ReqSigned = 1'b0;
        WrHi = 1'b0; WrLo = 1'b0; WrData = '0;
        hi_m = '0; lo_m = '0;
        #12;
        check("rst_hi", 32'(Hi), 32'd0);
        check("rst_lo", 32'(Lo), 32'd0);
        check("rst_busy", 32'(Busy), 32'd0);
        check("rst_done", 32'(Done), 32'd0);
        check("rst_ready", 32'(ReqReady), 32'd1);
        check("rst_start", 32'(MulStart), 32'd0);
        check("rst_mula", 32'({MulA, MulB}), 32'd0);
        @(negedge Clk); Reset = 1'b1;
        @(negedge Clk);

        run_op(16'd3, 16'd5, 1'b0, 1'b0, 16'd0, 16'd0, 1'b0, -1, -1, 16'd0, 16'd0);
        run_op(16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 16'd0, 16'd0, 1'b0, -1, -1, 16'd0, 16'd0);
        run_op(16'd7, 16'd9, 1'b0, 1'b1, 16'h1234, 16'h5678, 1'b0, -1, -1, 16'd0, 16'd0);
        run_op(16'h1234, 16'h5678, 1'b0, 1'b0, 16'd0, 16'd0, 1'b0, 10, MC + 1, 16'h1234, 16'hBEEF);
`ifdef MULT_SIGNED_EN
        run_op(16'hFFFD, 16'd5, 1'b1, 1'b0, 16'd0, 16'd0, 1'b0, -1, -1, 16'd0, 16'd0);
        check("sgn_neg", {Hi, Lo}, 32'hFFFF_FFF1);
        run_op(16'h8000, 16'h8000, 1'b1, 1'b0, 16'd0, 16'd0, 1'b0, -1, -1, 16'd0, 16'd0);
        check("sgn_min", {Hi, Lo}, 32'h4000_0000);
        run_op(16'h8000, 16'h8000, 1'b0, 1'b0, 16'd0, 16'd0, 1'b0, -1, -1, 16'd0, 16'd0);
        check("uns_min", {Hi, Lo}, 32'h4000_0000);
        run_op(16'h0000, 16'hFFFF, 1'b1, 1'b0, 16'd0, 16'd0, 1'b0, -1, -1, 16'd0, 16'd0);
        check("sgn_zero", {Hi, Lo}, 32'h0);
`endif

        // mthi while idle
        @(negedge Clk);
        WrHi = 1'b1; WrData = 16'hA5A5;
        @(posedge Clk); #1; WrHi = 1'b0; hi_m = 16'hA5A5;
        @(negedge Clk);
        check("idle_wrhi", 32'(Hi), 32'(hi_m));
        check("idle_lo", 32'(Lo), 32'(lo_m));

        ca = W'($urandom); cb = W'($urandom); cs = 1'($urandom);
        for (int i = 0; i < 24; i++) begin
            xa = W'($urandom); xb = W'($urandom); xs = 1'($urandom);
            hold = 1'($urandom);
            lk = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, MC + 1)) : -1;
            hk = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, MC + 1)) : -1;
            ld = W'($urandom); hd = W'($urandom);
            if (i % 5 == 0) begin ca = 16'hFFFF; cb = W'($urandom_range(0, 3)); end
            run_op(ca, cb, cs, hold, xa, xb, xs, lk, hk, ld, hd);
            ca = xa; cb = xb; cs = xs;
        end
        ReqValid = 1'b0;

        // asynchronous reset in the middle of RUN
        @(negedge Clk);
        ReqValid = 1'b1; OpA = 16'd7; OpB = 16'd9; ReqSigned = 1'b0;
        @(posedge Clk); #1; ReqValid = 1'b0;
        repeat (10) @(posedge Clk);
        #3 Reset = 1'b0;
        #1;
        check("abort_hi", 32'(Hi), 32'd0);
        check("abort_lo", 32'(Lo), 32'd0);
        check("abort_busy", 32'(Busy), 32'd0);
        check("abort_done", 32'(Done), 32'd0);
        check("abort_ready", 32'(ReqReady), 32'd1);
        check("abort_mul", 32'({MulA, MulB}), 32'd0);
        hi_m = '0; lo_m = '0;
        @(negedge Clk); Reset = 1'b1;
        bad = 0;
        for (int i = 0; i < MC + 10; i++) begin
            @(negedge Clk);
            if (Done || Busy || MulStart) bad++;
        end
        check("abort_no_done", 32'(bad), 32'd0);
        run_op(16'd3, 16'd5, 1'b0, 1'b0, 16'd0, 16'd0, 1'b0, -1, -1, 16'd0, 16'd0);
        check("post_abort", {Hi, Lo}, 32'h0000_000F);
        @(negedge Clk);
        check("done_pulse", 32'(Done), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
